// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 command decoder and its phrase-table reader.
package jt6295_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PHRASE  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAITACK = 3'd4
  } cmd_state_t;

  // Each phrase-table entry occupies eight bytes; only the first six are used.
  localparam int PHRASE_BYTES = 8;
  localparam int PHRASE_SHIFT = $clog2(PHRASE_BYTES);
  localparam int FETCH_BYTES  = 6;
  localparam int ADDR_W       = 18;

  // Isolates the lowest set bit of a 4-bit vector as a one-hot value.
  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Byte address of the first byte of a phrase-table entry.
  function automatic logic [ADDR_W-1:0] phrase_base(input logic [6:0] phrase);
    return ADDR_W'(phrase) << PHRASE_SHIFT;
  endfunction

endpackage

// File: rtl/jt6295_cmd_fetch.sv
// Reads the six address bytes of one phrase-table entry using the rom_ok handshake
// and assembles them into the sample start and stop addresses.
module jt6295_cmd_fetch
  import jt6295_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [6:0]  phrase,
  input  logic        rom_ok,
  input  logic [7:0]  rom_data,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  output logic        done,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr
);

  localparam logic [2:0] LAST_K = 3'(FETCH_BYTES - 1);

  logic [2:0] k;

  // Walk bytes 0..5 of the entry, advancing only on cycles where rom_ok confirms the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      k          <= '0;
      done       <= 1'b0;
      start_addr <= '0;
      stop_addr  <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        rom_cs   <= 1'b1;
        rom_addr <= phrase_base(phrase);
        k        <= '0;
      end else if (rom_cs && rom_ok) begin
        case (k)
          3'd0:    start_addr[17:16] <= rom_data[1:0];
          3'd1:    start_addr[15:8]  <= rom_data;
          3'd2:    start_addr[7:0]   <= rom_data;
          3'd3:    stop_addr[17:16]  <= rom_data[1:0];
          3'd4:    stop_addr[15:8]   <= rom_data;
          default: stop_addr[7:0]    <= rom_data;
        endcase
        if (k == LAST_K) begin
          rom_cs <= 1'b0;
          done   <= 1'b1;
        end else begin
          k        <= k + 3'd1;
          rom_addr <= rom_addr + 18'd1;
        end
      end
    end
  end

endmodule

// File: rtl/jt6295_cmd.sv
// CPU command decoder for the jt6295: accepts phrase/stop writes, fetches the phrase
// addresses from ROM and hands them to the channel engine one channel at a time.
module jt6295_cmd
  import jt6295_pkg::*;
#(
  parameter int ACK_TMO = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic        ready,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr,
  output logic [3:0]  att,
  output logic [3:0]  start,
  output logic [3:0]  stop,
  input  logic [3:0]  busy
);

  localparam int TMR_W = $clog2(ACK_TMO + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TMO - 1);

  cmd_state_t       state, state_nx;
  logic [6:0]       phrase, phrase_nx;
  logic [3:0]       pend, pend_nx;
  logic [3:0]       cur, cur_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [3:0]       att_nx, start_nx, stop_nx;
  logic [17:0]      start_addr_nx, stop_addr_nx;
  logic [3:0]       avail, pick;
  logic             go, fetch_done;
  logic [17:0]      fetch_start, fetch_stop;

  jt6295_cmd_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .phrase     (phrase),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .done       (fetch_done),
    .start_addr (fetch_start),
    .stop_addr  (fetch_stop)
  );

  assign ready = (state == ST_IDLE);
  // Channels still to be issued that the engine is not already playing.
  assign avail = pend & ~busy;
  assign pick  = lowest_bit(avail);

  // Next-state and next-output decode; stop writes are honoured in every state but PHRASE.
  always_comb begin
    state_nx      = state;
    phrase_nx     = phrase;
    pend_nx       = pend;
    cur_nx        = cur;
    timer_nx      = timer;
    att_nx        = att;
    start_nx      = 4'd0;
    stop_nx       = 4'd0;
    start_addr_nx = start_addr;
    stop_addr_nx  = stop_addr;
    go            = 1'b0;

    if (wr && !din[7] && state != ST_PHRASE) begin
      stop_nx = din[6:3];
    end

    case (state)
      ST_IDLE: begin
        if (wr && din[7]) begin
          phrase_nx = din[6:0];
          state_nx  = ST_PHRASE;
        end
      end
      ST_PHRASE: begin
        if (wr) begin
          if (phrase == 7'd0 || din[7:4] == 4'd0) begin
            state_nx = ST_IDLE;
          end else begin
            pend_nx  = din[7:4];
            att_nx   = din[3:0];
            go       = 1'b1;
            state_nx = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (fetch_done) begin
          start_addr_nx = fetch_start;
          stop_addr_nx  = fetch_stop;
          state_nx      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pick == 4'd0) begin
          pend_nx  = 4'd0;
          state_nx = ST_IDLE;
        end else begin
          start_nx = pick;
          cur_nx   = pick;
          // Drop the issued channel and the busy ones scanned past below it.
          pend_nx  = pend & ~(pick | (pick - 4'd1));
          timer_nx = '0;
          state_nx = ST_WAITACK;
        end
      end
      ST_WAITACK: begin
        if (|(cur & (busy | stop))) begin
          state_nx = ST_ISSUE;
        end else if (timer == TMR_LAST) begin
          state_nx = ST_ISSUE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command context and registered outputs to the channel engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phrase     <= '0;
      pend       <= '0;
      cur        <= '0;
      timer      <= '0;
      att        <= '0;
      start      <= '0;
      stop       <= '0;
      start_addr <= '0;
      stop_addr  <= '0;
    end else begin
      phrase     <= phrase_nx;
      pend       <= pend_nx;
      cur        <= cur_nx;
      timer      <= timer_nx;
      att        <= att_nx;
      start      <= start_nx;
      stop       <= stop_nx;
      start_addr <= start_addr_nx;
      stop_addr  <= stop_addr_nx;
    end
  end

endmodule

// File: doc/jt6295_cmd.md
JT6295_CMD -- requirements
Module: jt6295_cmd

Interface
REQ-001 SHALL have parameter ACK_TMO, default 63, max clocks to wait for channel busy acknowledge.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr  in  1  CPU write strobe, one byte per high cycle.
REQ-005 SHALL have port din  in  8  CPU write data.
REQ-006 SHALL have port ready  out  1  high when idle and able to accept a phrase command.
REQ-007 SHALL have port rom_cs  out  1  phrase-table read request.
REQ-008 SHALL have port rom_addr  out  18  phrase-table byte address.
REQ-009 SHALL have port rom_data  in  8  ROM read data.
REQ-010 SHALL have port rom_ok  in  1  rom_data valid for current rom_addr.
REQ-011 SHALL have port start_addr  out  18  sample start address to serial channel engine.
REQ-012 SHALL have port stop_addr  out  18  sample stop address to serial channel engine.
REQ-013 SHALL have port att  out  4  attenuation to channel engine.
REQ-014 SHALL have port start  out  4  one-hot channel start pulse.
REQ-015 SHALL have port stop  out  4  channel stop mask pulse.
REQ-016 SHALL have port busy  in  4  per-channel busy from channel engine.

Function
REQ-017 SHALL decode wr byte with din[7]=1 in IDLE as phrase select: latch din[6:0], go to PHRASE.
REQ-018 SHALL, in PHRASE, take next wr byte as mask=din[7:4], att=din[3:0], go to FETCH; phrase 0 or mask 0 returns to IDLE with no fetch.
REQ-019 SHALL decode wr byte with din[7]=0 in IDLE or FETCH/ISSUE/WAITACK as stop: pulse stop=din[6:3] one cycle, next clock; FSM state unchanged.
REQ-020 SHALL ignore din[7]=1 writes while not in IDLE or PHRASE; ready=1 only in IDLE.
REQ-021 SHALL, in FETCH, read six bytes k=0..5 at rom_addr={phrase,3'b000}+k zero-extended, rom_cs held high, advancing k on each rom_ok cycle.
REQ-022 SHALL form start_addr={b0[1:0],b1,b2}, stop_addr={b3[1:0],b4,b5}; upper bits of b0/b3 discarded.
REQ-023 SHALL, in ISSUE, scan remaining mask bits lowest index first, skipping any channel with busy[i]=1 at scan time.
REQ-024 SHALL pulse start[i] exactly one cycle per issued channel, start_addr/stop_addr/att stable from that cycle until leaving WAITACK.
REQ-025 SHALL, in WAITACK, return to ISSUE when busy[i]=1 or after ACK_TMO clocks (drop channel); IDLE when mask exhausted.
REQ-026 SHALL never assert more than one start bit in a cycle.
REQ-027 SHALL, when a stop pulse covers the channel in WAITACK, treat it as acknowledged and continue scan.
REQ-028 SHALL accept stop_addr<start_addr without check.
REQ-029 SHALL hold rom_cs low outside FETCH.
REQ-030 SHALL have latency wr(second byte) to first start pulse = 6 rom_ok cycles + 2 clocks when rom_ok tied high.

Reset
REQ-031 SHALL, on rst_n low, immediately force IDLE, ready=1, rom_cs=0, start=0, stop=0, rom_addr=0, start_addr=0, stop_addr=0, att=0.
REQ-032 SHALL abandon any fetch or issue in progress on reset mid-operation; no start pulse after release until a new command.

Structure
REQ-033 SHALL put FSM state encodings (IDLE, PHRASE, FETCH, ISSUE, WAITACK) and phrase-entry size 8 in shared package jt6295_pkg.
REQ-034 SHALL contain one sub-module jt6295_cmd_fetch: 6-byte ROM reader with rom_ok handshake.

Verification
REQ-035 SHALL test wr 0x81 then 0x13, ROM bytes at 8..13 = 01 23 45 02 00 10, rom_ok=1 -> start=0001, start_addr=0x12345, stop_addr=0x20010, att=3.
REQ-036 SHALL test mask 0xF with busy=0100 and engine acking each start -> start pulses 0001,0010,1000 in order, none on channel 2.
REQ-037 SHALL test wr 0x28 during FETCH -> stop=0101 one cycle, fetch completes unaltered.
REQ-038 SHALL test busy never rising with ACK_TMO=63 -> next start issued 64 clocks later, ready=1 after last.
REQ-039 SHALL test rst_n low during byte 3 fetch -> rom_cs=0 same cycle, no start pulse after release, ready=1.
REQ-040 SHALL test phrase 0x80 then 0xF0 -> no rom_cs, ready back to 1 next clock.
